// File: rtl/bfp16_multiplier.sv
// bfp16_multiplier: registered bfloat16 multiplier with round-to-nearest-even.
// Handles signed zeros, subnormals, infinities and NaN (canonical 0x7FC0).
// One operand pair per clock; the product appears on O one cycle later.
module bfp16_multiplier #(
    parameter int unsigned DATA_TYPE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] A,
    input  logic [DATA_TYPE-1:0] B,
    output logic [DATA_TYPE-1:0] O
);

    // Operand fields and classification
    logic       sign_a, sign_b, sign_r;
    logic [7:0] exp_a, exp_b;
    logic [6:0] frac_a, frac_b;
    logic       zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    assign sign_a = A[15];
    assign sign_b = B[15];
    assign exp_a  = A[14:7];
    assign exp_b  = B[14:7];
    assign frac_a = A[6:0];
    assign frac_b = B[6:0];
    assign sign_r = sign_a ^ sign_b;

    assign zero_a = (exp_a == 8'd0) && (frac_a == 7'd0);
    assign zero_b = (exp_b == 8'd0) && (frac_b == 7'd0);
    assign inf_a  = (exp_a == 8'hFF) && (frac_a == 7'd0);
    assign inf_b  = (exp_b == 8'hFF) && (frac_b == 7'd0);
    assign nan_a  = (exp_a == 8'hFF) && (frac_a != 7'd0);
    assign nan_b  = (exp_b == 8'hFF) && (frac_b != 7'd0);

    // Count of leading zeros in a 16-bit value (16 when the value is zero)
    function automatic logic [4:0] lzc16(input logic [15:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 5'd1;
                end
            end
        end
        return n;
    endfunction

    logic [7:0]        sig_a, sig_b;
    logic [7:0]        eff_a, eff_b;
    logic [15:0]       prod;
    logic [4:0]        lz;
    logic [15:0]       norm;
    logic signed [9:0] exp_n;
    logic              uf;
    logic [9:0]        sh;
    logic [31:0]       ext;
    logic [31:0]       shifted;
    logic              lost;
    logic              guard, sticky, inc;
    logic              carry;
    logic [7:0]        mant_r;
    logic signed [9:0] exp_f;
    logic [15:0]       res;

    // Finite datapath: multiply, normalize, denormalize on underflow, round, then special-case mux
    always_comb begin
        sig_a   = {~(exp_a == 8'd0), frac_a};
        sig_b   = {~(exp_b == 8'd0), frac_b};
        eff_a   = (exp_a == 8'd0) ? 8'd1 : exp_a;
        eff_b   = (exp_b == 8'd0) ? 8'd1 : exp_b;
        prod    = sig_a * sig_b;
        lz      = lzc16(prod);
        norm    = prod << lz;
        // Product MSB sits at bit 15 with biased weight eA + eB - 127 + 1
        exp_n   = $signed({2'b00, eff_a}) + $signed({2'b00, eff_b}) - 10'sd126
                  - $signed({5'b00000, lz});
        uf      = (exp_n <= 10'sd0);
        sh      = $unsigned(10'sd1 - exp_n);
        ext     = {norm, 16'h0000};
        shifted = ext;
        lost    = 1'b0;
        if (uf) begin
            if (sh >= 10'd32) begin
                shifted = 32'h0;
                lost    = |norm;
            end else begin
                shifted = ext >> sh[4:0];
                lost    = ((shifted << sh[4:0]) != ext);
            end
        end
        guard  = shifted[23];
        sticky = (|shifted[22:0]) | lost;
        inc    = guard & (sticky | shifted[24]);
        {carry, mant_r} = {1'b0, shifted[31:24]} + {8'h00, inc};
        // Subnormals that round up into bit 7 become the smallest normal
        exp_f  = uf ? $signed({9'd0, mant_r[7]}) : (exp_n + $signed({9'd0, carry}));

        res = {sign_r, exp_f[7:0], mant_r[6:0]};
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            res = 16'h7FC0;
        end else if (inf_a || inf_b) begin
            res = {sign_r, 8'hFF, 7'h00};
        end else if (zero_a || zero_b) begin
            res = {sign_r, 15'h0000};
        end else if (exp_f >= 10'sd255) begin
            res = {sign_r, 8'hFF, 7'h00};
        end
    end

    // Output register, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            O <= '0;
        end else begin
            O <= res;
        end
    end

endmodule

// File: tb/tb_bfp16_multiplier.sv
// tb_bfp16_multiplier: directed and randomized checks of bfp16_multiplier against a
// real-arithmetic reference that rounds the exact product to bfloat16.
module tb_bfp16_multiplier;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] O;

    int n_cmp = 0;
    int n_bad = 0;

    bfp16_multiplier #(.DATA_TYPE(16)) dut (
        .clk(clk),
        .rst(rst),
        .A  (A),
        .B  (B),
        .O  (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) begin
            for (int i = 0; i < e; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -e; i++) r = r / 2.0;
        end
        return r;
    endfunction

    // floor(log2(v)) for a positive normal double
    function automatic int flog2(input real v);
        logic [63:0] bits;
        bits = $realtobits(v);
        return int'(bits[62:52]) - 1023;
    endfunction

    // Reference: exact product as a real, rounded RNE onto the bfloat16 grid
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic       s;
        int         ea, eb, fa, fb, ma, mb, k, qe, e, f, fs;
        real        v, n, nr, fr, r;
        logic [7:0] ef;
        logic [6:0] ff;
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        fa = int'(a[6:0]);
        fb = int'(b[6:0]);
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 16'h7FC0;
        if ((ea == 255 && eb == 0 && fb == 0) || (eb == 255 && ea == 0 && fa == 0))
            return 16'h7FC0;
        if (ea == 255 || eb == 255) return {s, 8'hFF, 7'h00};
        if ((ea == 0 && fa == 0) || (eb == 0 && fb == 0)) return {s, 15'h0000};
        ma = (ea == 0) ? fa : 128 + fa;
        mb = (eb == 0) ? fb : 128 + fb;
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        v  = real'(ma * mb) * pow2(ea + eb - 254 - 14);
        k  = flog2(v);
        qe = k - 7;
        if (qe < -133) qe = -133;
        n  = v / pow2(qe);
        nr = $floor(n);
        fr = n - nr;
        if (fr > 0.5 || (fr == 0.5 && (int'(nr) % 2) == 1)) nr = nr + 1.0;
        r = nr * pow2(qe);
        if (r == 0.0) return {s, 15'h0000};
        if (r >= pow2(128)) return {s, 8'hFF, 7'h00};
        if (r < pow2(-126)) begin
            fs = int'(r / pow2(-133));
            ff = fs[6:0];
            return {s, 8'h00, ff};
        end
        e  = flog2(r);
        f  = int'(r / pow2(e) * 128.0) - 128;
        fs = e + 127;
        ef = fs[7:0];
        ff = f[6:0];
        return {s, ef, ff};
    endfunction

    // Random operand biased towards the interesting classes
    function automatic logic [15:0] rand_op();
        logic [15:0] x;
        int          c;
        x = 16'($urandom);
        c = int'($urandom_range(0, 9));
        case (c)
            0: x[14:0] = 15'h0000;
            1: x[14:7] = 8'h00;
            2: begin x[14:7] = 8'hFF; x[6:0] = 7'h00; end
            3: begin x[14:7] = 8'hFF; if (x[6:0] == 7'h00) x[0] = 1'b1; end
            4: x[14:7] = 8'($urandom_range(1, 12));
            5: x[14:7] = 8'($urandom_range(240, 254));
            6: x[14:7] = 8'($urandom_range(60, 70));
            default: ;
        endcase
        return x;
    endfunction

    // Called at a falling edge; drives, checks #1 after the next rising edge, returns at falling
    task automatic run_exp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                           input string tag);
        A = a;
        B = b;
        @(posedge clk);
        #1 check_eq(tag, O, exp);
        @(negedge clk);
    endtask

    logic [15:0] sub_b   [4] = '{16'h3F02, 16'h3F82, 16'h4002, 16'h4082};
    logic [15:0] sub_exp [4] = '{16'h0020, 16'h0040, 16'h0080, 16'h0100};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        rst = 1'b0;
        A   = 16'h3F80;
        B   = 16'h3F80;
        // Reset held: inputs toggle, output must stay zero across edges
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check_eq("rst_hold", O, 16'h0000);
            A = 16'($urandom);
            B = 16'h3F80;
        end
        @(negedge clk);
        rst = 1'b1;

        run_exp(16'h3F80, 16'h3F80, 16'h3F80, "one_one");
        run_exp(16'h4000, 16'h4040, 16'h40C0, "two_three");
        run_exp(16'hBF80, 16'h4000, 16'hC000, "neg_two");
        run_exp(16'h3F81, 16'h3F81, 16'h3F82, "sq_3f81");
        run_exp(16'h3F81, 16'h4040, 16'h4042, "tie_up");
        run_exp(16'h3F83, 16'h4040, 16'h4044, "tie_down");
        for (int i = 0; i < 8; i++) begin
            run_exp(16'h003F, sub_b[i % 4], sub_exp[i % 4], "sub_stream");
        end
        run_exp(16'h7F00, 16'h4000, 16'h7F80, "overflow");
        run_exp(16'h7F80, 16'h0000, 16'h7FC0, "inf_zero");
        run_exp(16'hFF80, 16'h3F80, 16'hFF80, "neg_inf");
        run_exp(16'h7FC1, 16'h3F80, 16'h7FC0, "nan_in");
        run_exp(16'h8000, 16'h4000, 16'h8000, "neg_zero");
        run_exp(16'h0080, 16'h3F00, 16'h0040, "uf_half");
        run_exp(16'h0001, 16'h3F00, 16'h0000, "uf_tie_zero");
        run_exp(16'h007F, 16'h3F81, 16'h0080, "uf_to_normal");

        // Asynchronous reset mid-stream, no clock edge between assert and check
        run_exp(16'h3F80, 16'h4000, 16'h4000, "pre_rst");
        #1 rst = 1'b0;
        #1 check_eq("rst_async", O, 16'h0000);
        A = 16'h4000;
        B = 16'h4040;
        @(posedge clk);
        #1 check_eq("rst_low_edge", O, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        run_exp(16'h4000, 16'h4040, 16'h40C0, "post_rst");

        for (int i = 0; i < 3000; i++) begin
            ra = rand_op();
            rb = rand_op();
            run_exp(ra, rb, ref_mul(ra, rb), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
